// File: rtl/circuito_exp4_pkg.sv
// Shared constants for the memory-sequence game: widths, FSM state codes,
// the fixed play sequence and the hex-to-seven-segment table.
package circuito_exp4_pkg;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 4;
    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] S_INICIAL     = 4'h0;
    localparam logic [STATE_W-1:0] S_PREPARACAO  = 4'h1;
    localparam logic [STATE_W-1:0] S_ESPERA      = 4'h2;
    localparam logic [STATE_W-1:0] S_REGISTRA    = 4'h4;
    localparam logic [STATE_W-1:0] S_COMPARACAO  = 4'h5;
    localparam logic [STATE_W-1:0] S_PROXIMO     = 4'h6;
    localparam logic [STATE_W-1:0] S_FIM_ACERTOU = 4'hA;
    localparam logic [STATE_W-1:0] S_FIM_ERROU   = 4'hE;

    function automatic logic [DATA_W-1:0] rom_read(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] data;
        case (addr)
            4'h0: data = 4'h1;
            4'h1: data = 4'h2;
            4'h2: data = 4'h4;
            4'h3: data = 4'h8;
            4'h4: data = 4'h4;
            4'h5: data = 4'h2;
            4'h6: data = 4'h1;
            4'h7: data = 4'h1;
            4'h8: data = 4'h2;
            4'h9: data = 4'h2;
            4'hA: data = 4'h4;
            4'hB: data = 4'h4;
            4'hC: data = 4'h8;
            4'hD: data = 4'h8;
            4'hE: data = 4'h1;
            default: data = 4'h4;
        endcase
        return data;
    endfunction

    // Segment order is gfedcba, active-low (0 lights the segment).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/circuito_exp4_hexa7seg.sv
// Hex digit to seven-segment decoder (gfedcba, active-low), reused for
// every debug display.
module hexa7seg
    import circuito_exp4_pkg::*;
(
    input  logic [3:0] hexa,
    output logic [6:0] display
);

    assign display = hex_to_seg(hexa);

endmodule

// File: rtl/circuito_exp4.sv
// Memory-sequence game: the player must repeat the 16-entry ROM sequence
// one switch press at a time; the FSM reports win or lose.
module circuito_exp4
    import circuito_exp4_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       acertou,
    output logic       errou,
    output logic       pronto,
    output logic [3:0] leds,
    output logic       db_igual,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogada,
    output logic       db_clock,
    output logic       db_iniciar,
    output logic       db_tem_jogada
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic [ADDR_W-1:0]  count;
    logic [DATA_W-1:0]  jogada;
    logic [DATA_W-1:0]  rom_data;
    logic               tem_jogada;
    logic               tem_jogada_prev;
    logic               jogada_feita;
    logic               igual;
    logic               fim_mem;

    assign tem_jogada   = |chaves;
    assign jogada_feita = tem_jogada & ~tem_jogada_prev;
    assign rom_data     = rom_read(count);
    assign igual        = (jogada == rom_data);
    assign fim_mem      = (count == 4'hF);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tem_jogada_prev <= 1'b0;
        end else begin
            tem_jogada_prev <= tem_jogada;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (state == S_PREPARACAO) begin
            count <= '0;
        end else if (state == S_PROXIMO) begin
            count <= count + 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            jogada <= '0;
        end else if (state == S_PREPARACAO) begin
            jogada <= '0;
        end else if (state == S_REGISTRA) begin
            jogada <= chaves;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_INICIAL;
        end else begin
            state <= next_state;
        end
    end

    // Unused encodings fall into the default arm and recover to inicial.
    always_comb begin
        next_state = S_INICIAL;
        case (state)
            S_INICIAL:     next_state = iniciar ? S_PREPARACAO : S_INICIAL;
            S_PREPARACAO:  next_state = S_ESPERA;
            S_ESPERA:      next_state = jogada_feita ? S_REGISTRA : S_ESPERA;
            S_REGISTRA:    next_state = S_COMPARACAO;
            S_COMPARACAO: begin
                if (!igual)       next_state = S_FIM_ERROU;
                else if (fim_mem) next_state = S_FIM_ACERTOU;
                else              next_state = S_PROXIMO;
            end
            S_PROXIMO:     next_state = S_ESPERA;
            S_FIM_ACERTOU: next_state = iniciar ? S_PREPARACAO : S_FIM_ACERTOU;
            S_FIM_ERROU:   next_state = iniciar ? S_PREPARACAO : S_FIM_ERROU;
            default:       next_state = S_INICIAL;
        endcase
    end

    assign acertou = (state == S_FIM_ACERTOU);
    assign errou   = (state == S_FIM_ERROU);
    assign pronto  = acertou | errou;

    assign leds          = chaves;
    assign db_igual      = igual;
    assign db_clock      = clock;
    assign db_iniciar    = iniciar;
    assign db_tem_jogada = tem_jogada;

    hexa7seg u_hex_contagem (.hexa(count),    .display(db_contagem));
    hexa7seg u_hex_memoria  (.hexa(rom_data), .display(db_memoria));
    hexa7seg u_hex_estado   (.hexa(state),    .display(db_estado));
    hexa7seg u_hex_jogada   (.hexa(jogada),   .display(db_jogada));

endmodule

// File: tb/tb_circuito_exp4.sv
// Self-checking bench for circuito_exp4: expected FSM state trace is queued
// as plays are driven and checked as db_estado changes.
module tb_circuito_exp4;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] chaves;
    logic       acertou;
    logic       errou;
    logic       pronto;
    logic [3:0] leds;
    logic       db_igual;
    logic [6:0] db_contagem;
    logic [6:0] db_memoria;
    logic [6:0] db_estado;
    logic [6:0] db_jogada;
    logic       db_clock;
    logic       db_iniciar;
    logic       db_tem_jogada;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] rom_model [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                                   4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [3:0] exp_q [$];
    int         exp_count = 0;
    bit         mon_en = 1'b0;
    logic [6:0] prev_seg;

    circuito_exp4 dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
        .acertou(acertou), .errou(errou), .pronto(pronto), .leds(leds),
        .db_igual(db_igual), .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_estado(db_estado), .db_jogada(db_jogada), .db_clock(db_clock),
        .db_iniciar(db_iniciar), .db_tem_jogada(db_tem_jogada)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input logic [3:0] v);
        return seg_tab[v];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Every visible state change must match the head of the expected trace.
    always @(negedge clock) begin
        if (mon_en && db_estado !== prev_seg) begin
            if (exp_q.size() == 0)
                checkOutput("unexpected_state", {25'd0, db_estado}, {25'd0, prev_seg});
            else
                checkOutput("state_seq", {25'd0, db_estado}, {25'd0, seg(exp_q.pop_front())});
            prev_seg = db_estado;
        end
    end

    task automatic startGame(input int n);
        exp_q.push_back(4'h1);
        exp_q.push_back(4'h2);
        iniciar = 1'b1;
        cycles(n);
        iniciar = 1'b0;
        cycles(2);
        exp_count = 0;
    endtask

    task automatic applyStimulus(input logic [3:0] v, input int hold, input int gap);
        exp_q.push_back(4'h4);
        exp_q.push_back(4'h5);
        if (v == rom_model[exp_count]) begin
            if (exp_count == 15) begin
                exp_q.push_back(4'hA);
            end else begin
                exp_q.push_back(4'h6);
                exp_q.push_back(4'h2);
                exp_count++;
            end
        end else begin
            exp_q.push_back(4'hE);
        end
        chaves = v;
        cycles(hold);
        chaves = 4'h0;
        cycles(gap);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        chaves  = 4'h0;
        cycles(2);
        reset = 1'b0;
        cycles(10);
        checkOutput("rst_estado",   db_estado,   seg(4'h0));
        checkOutput("rst_contagem", db_contagem, seg(4'h0));
        checkOutput("rst_memoria",  db_memoria,  seg(4'h1));
        checkOutput("rst_results",  {acertou, errou, pronto}, 3'b000);
        prev_seg = db_estado;
        mon_en   = 1'b1;

        startGame(5);
        checkOutput("start_estado",   db_estado,   seg(4'h2));
        checkOutput("start_contagem", db_contagem, seg(4'h0));

        applyStimulus(4'h1, 10, 10);
        applyStimulus(4'h2, 10, 10);
        applyStimulus(4'h4, 10, 10);
        checkOutput("three_contagem", db_contagem, seg(4'h3));
        checkOutput("three_errou",    errou, 1'b0);

        applyStimulus(4'h1, 5, 5);
        checkOutput("lose_results", {acertou, errou, pronto}, 3'b011);
        checkOutput("lose_jogada",  db_jogada, seg(4'h1));
        checkOutput("lose_igual",   db_igual, 1'b0);
        checkOutput("lose_estado",  db_estado, seg(4'hE));

        startGame(3);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(rom_model[i], 4, 2);
        end
        checkOutput("win_estado",  db_estado, seg(4'hA));
        checkOutput("win_results", {acertou, errou, pronto}, 3'b101);
        checkOutput("win_igual",   db_igual, 1'b1);

        startGame(4);
        checkOutput("restart_contagem", db_contagem, seg(4'h0));
        checkOutput("restart_jogada",   db_jogada, seg(4'h0));
        checkOutput("restart_results",  {acertou, errou, pronto}, 3'b000);

        chaves = 4'h1;
        #1;
        checkOutput("leds_echo", {leds, db_tem_jogada}, 5'b00011);
        chaves = 4'h0;
        applyStimulus(4'h1, 20, 2);
        checkOutput("hold_contagem", db_contagem, seg(4'h1));

        exp_q.push_back(4'h4);
        exp_q.push_back(4'h5);
        chaves = 4'h2;
        cycles(2);
        @(negedge clock);
        #1;
        exp_q.push_back(4'h0);
        reset = 1'b1;
        #1;
        checkOutput("midreset_estado", db_estado, seg(4'h0));
        cycles(2);
        reset  = 1'b0;
        chaves = 4'h0;
        cycles(5);
        checkOutput("post_reset_estado",   db_estado,   seg(4'h0));
        checkOutput("post_reset_contagem", db_contagem, seg(4'h0));

        mon_en = 1'b0;
        checkOutput("trace_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/circuito_exp4.md
CIRCUITO_EXP4 -- requirements
Module: circuito_exp4

Interface
REQ-001 Parameters: none; ROM depth 16, data width 4, both fixed.
REQ-002 clock  in  1  system clock, all state updates on rising edge.
REQ-003 reset  in  1  one clock; reset is asynchronous and active-high.
REQ-004 iniciar  in  1  level; starts or restarts a game.
REQ-005 chaves  in  4  player switches; one-hot play expected.
REQ-006 acertou  out  1  high in final-win state.
REQ-007 errou  out  1  high in final-lose state.
REQ-008 pronto  out  1  high in either final state.
REQ-009 leds  out  4  equals chaves (combinational echo).
REQ-010 db_igual  out  1  comparator result (jogada register == ROM data).
REQ-011 db_contagem  out  7  7-seg of address counter.
REQ-012 db_memoria  out  7  7-seg of ROM data.
REQ-013 db_estado  out  7  7-seg of FSM state code.
REQ-014 db_jogada  out  7  7-seg of jogada register.
REQ-015 db_clock, db_iniciar, db_tem_jogada  out  1 each  copy clock, copy iniciar, OR of chaves.

Function
REQ-016 ROM, address 0..15, SHALL hold: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4 (hex, 4-bit).
REQ-017 Address counter SHALL be 4-bit; cleared in preparacao; +1 in proximo; fim_mem = (count == 15).
REQ-018 tem_jogada = OR(chaves); edge detector SHALL register tem_jogada and assert jogada_feita for exactly one cycle on its 0->1 transition.
REQ-019 jogada register (4-bit) SHALL be cleared in preparacao and load chaves in registra.
REQ-020 igual SHALL be combinational (jogada == ROM[count]).
REQ-021 FSM states/codes: inicial=0, preparacao=1, espera=2, registra=4, comparacao=5, proximo=6, fim_acertou=A, fim_errou=E.
REQ-022 inicial: iniciar=1 -> preparacao, else stay.
REQ-023 preparacao -> espera unconditionally (one cycle).
REQ-024 espera: jogada_feita=1 -> registra, else stay.
REQ-025 registra -> comparacao unconditionally.
REQ-026 comparacao: igual=0 -> fim_errou; igual=1 and fim_mem=1 -> fim_acertou; igual=1 and fim_mem=0 -> proximo.
REQ-027 proximo -> espera unconditionally.
REQ-028 fim_acertou/fim_errou: hold until iniciar=1 -> preparacao.
REQ-029 acertou, errou, pronto SHALL be Moore outputs decoded from state only.
REQ-030 Holding chaves nonzero SHALL register only one play; a new play requires chaves to return to 0 first.
REQ-031 iniciar held multiple cycles SHALL cause no effect beyond entering preparacao once per idle/final state.
REQ-032 Unused state encodings SHALL return to inicial on next clock.
REQ-033 7-seg encoding: segments gfedcba, active-low, full hex 0-F; 4-bit values zero-extended.

Reset
REQ-034 reset=1 SHALL immediately force state inicial, counter 0, jogada register 0, edge-detector register 0.
REQ-035 After reset: acertou=errou=pronto=0, db_estado shows 0, db_contagem shows 0, db_memoria shows 1.
REQ-036 reset mid-game SHALL abandon the game; iniciar needed to restart.

Structure
REQ-037 Shared package: state codes, ROM contents, widths.
REQ-038 One reusable sub-module hexa7seg (4-bit in, 7-bit active-low out), instantiated four times; datapath and FSM in the top module.

Verification
REQ-039 Reset pulse, wait 10 cycles -> state 0, all result outputs 0, counter 0.
REQ-040 iniciar=1 for 5 cycles -> state 1 then 2, counter 0, single pass through preparacao.
REQ-041 Plays 1,2,4 each held 10 cycles with 10-cycle gaps -> each via 4,5,6; counter ends at 3; errou=0.
REQ-042 Then play 1 (expected 8) for 5 cycles -> state E, errou=1, pronto=1, acertou=0, db_jogada shows 1.
REQ-043 All 16 correct plays -> state A, acertou=1, pronto=1; iniciar=1 -> state 1, counter 0, outputs 0.
REQ-044 chaves=1 held 20 cycles in espera -> exactly one registra; reset asserted mid-compare -> state 0 at once.
